// File: rtl/pipeline_register_param.sv
// Pipeline stage register with a HALT/RUN/STEP run-control FSM gating stage advance.
// Optional stall/flush statistics counters are built only when PIPE_REG_STATS_EN is defined.
module pipeline_register_param #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned NUM_DATA  = 5,
    parameter int unsigned NUM_FLAGS = 16
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         exec,
    input  logic                         halt_cmd,
    input  logic                         step,
    input  logic                         enable,
    input  logic                         stall,
    input  logic                         flush,
    input  logic                         ivalid,
    input  logic [NUM_DATA*DATA_W-1:0]   idata,
    input  logic [NUM_FLAGS-1:0]         iflags,
    output logic [NUM_DATA*DATA_W-1:0]   odata,
    output logic [NUM_FLAGS-1:0]         oflags,
    output logic                         ovalid,
    output logic                         halted,
    output logic [1:0]                   state,
    output logic [15:0]                  stall_count,
    output logic [15:0]                  flush_count
);

    localparam int unsigned BUS_W = NUM_DATA * DATA_W;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               halted_q, halted_d;
    logic [BUS_W-1:0]   data_q, data_d;
    logic [NUM_FLAGS-1:0] flags_q, flags_d;
    logic               valid_q, valid_d;
    logic               adv_c;
    logic               upd_c;

    // Run control: exec acts in its own cycle, halt_cmd blocks the update in its own cycle.
    always_comb begin
        state_d = state_q;
        adv_c   = 1'b0;
        unique case (state_q)
            ST_HALT: begin
                adv_c = exec & ~halt_cmd;
                if (exec && !halt_cmd) begin
                    state_d = ST_RUN;
                end else if (step && !halt_cmd) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN: begin
                adv_c = ~exec & ~halt_cmd;
                if (exec || halt_cmd) begin
                    state_d = ST_HALT;
                end
            end
            ST_STEP: begin
                adv_c   = ~halt_cmd;
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
        halted_d = (state_d != ST_RUN);
    end

    assign upd_c = adv_c & enable;

    // Stage datapath: stall holds, flush clears, otherwise load.
    always_comb begin
        data_d  = data_q;
        flags_d = flags_q;
        valid_d = valid_q;
        if (upd_c && !stall) begin
            if (flush) begin
                data_d  = '0;
                flags_d = '0;
                valid_d = 1'b0;
            end else begin
                data_d  = idata;
                flags_d = iflags;
                valid_d = ivalid;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
            data_q   <= '0;
            flags_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
            data_q   <= data_d;
            flags_q  <= flags_d;
            valid_q  <= valid_d;
        end
    end

    assign odata  = data_q;
    assign oflags = flags_q;
    assign ovalid = valid_q;
    assign halted = halted_q;
    assign state  = state_q;

`ifdef PIPE_REG_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (upd_c && stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (upd_c && !stall && flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule
